// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides. Base RV32I ops finish in one
// cycle; RV32M multiply/divide share an iterative 1-bit/cycle datapath with a sign fix-up step.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      aluOp_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7_5_i,
  input  logic            funct7_0_i,
  input  logic            op5_i,
  input  logic [XLEN-1:0] operandA_i,
  input  logic [XLEN-1:0] operandB_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            branchTaken_o,
  output logic [1:0]      state_o
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW-1:0]  LAST_IT = SHW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic [SHW-1:0]      cnt_q;
  logic [2*XLEN-1:0]   p_q;
  logic [XLEN-1:0]     opnd_q;
  logic [1:0]          m_f3_q;
  logic                is_div_q;
  logic                neg_q;
  logic                neg_r_q;
  logic [XLEN-1:0]     result_q;
  logic                branch_q;

  // Handshake: a request transfers on a rising edge where valid_i & ready_o; a result
  // transfers on a rising edge where valid_o & ready_i. valid_i is not required to hold.
  logic accept;
  assign ready_o = !flush_i && (state_q == IDLE || (state_q == DONE && ready_i));
  assign accept  = valid_i && ready_o;
  assign valid_o       = (state_q == DONE);
  assign result_o      = result_q;
  assign branchTaken_o = branch_q;
  assign state_o       = state_q;

  // Base integer datapath
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sum_ab;
  logic [XLEN-1:0] diff_ab;
  logic [XLEN-1:0] sra_res;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] base_res;
  logic            base_br;

  assign shamt   = operandB_i[SHW-1:0];
  assign sum_ab  = operandA_i + operandB_i;
  assign diff_ab = operandA_i - operandB_i;
  assign sra_res = $signed(operandA_i) >>> shamt;
  assign lt_s    = $signed(operandA_i) < $signed(operandB_i);
  assign lt_u    = operandA_i < operandB_i;

  always_comb begin
    base_res = sum_ab;
    base_br  = 1'b0;
    case (aluOp_i)
      2'b01: begin
        base_res = diff_ab;
        case (funct3_i)
          3'b000:  base_br = (operandA_i == operandB_i);
          3'b001:  base_br = (operandA_i != operandB_i);
          3'b100:  base_br = lt_s;
          3'b101:  base_br = !lt_s;
          3'b110:  base_br = lt_u;
          3'b111:  base_br = !lt_u;
          default: base_br = 1'b0;
        endcase
      end
      2'b10: begin
        case (funct3_i)
          3'b000:  base_res = (op5_i && funct7_5_i) ? diff_ab : sum_ab;
          3'b001:  base_res = operandA_i << shamt;
          3'b010:  base_res = {{(XLEN-1){1'b0}}, lt_s};
          3'b011:  base_res = {{(XLEN-1){1'b0}}, lt_u};
          3'b100:  base_res = operandA_i ^ operandB_i;
          3'b101:  base_res = funct7_5_i ? sra_res : (operandA_i >> shamt);
          3'b110:  base_res = operandA_i | operandB_i;
          default: base_res = operandA_i & operandB_i;
        endcase
      end
      default: base_res = sum_ab;
    endcase
  end

  // M-extension decode and operand conditioning
  logic            is_m;
  logic            m_div;
  logic            a_signed;
  logic            b_signed;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic            fast;
  logic [XLEN-1:0] fast_res;

  assign is_m     = ENABLE_M && (aluOp_i == 2'b10) && op5_i && funct7_0_i;
  assign m_div    = funct3_i[2];
  // mul (000) is sign-agnostic in its low half, so it runs unsigned.
  assign a_signed = m_div ? !funct3_i[0] : (funct3_i == 3'b001 || funct3_i == 3'b010);
  assign b_signed = m_div ? !funct3_i[0] : (funct3_i == 3'b001);
  assign sign_a   = a_signed && operandA_i[XLEN-1];
  assign sign_b   = b_signed && operandB_i[XLEN-1];
  assign mag_a    = sign_a ? -operandA_i : operandA_i;
  assign mag_b    = sign_b ? -operandB_i : operandB_i;
  assign div_zero = (operandB_i == '0);
  assign div_ovf  = !funct3_i[0] && (operandA_i == MIN_NEG) && (operandB_i == '1);
  assign fast     = m_div && (div_zero || div_ovf);

  always_comb begin
    fast_res = '0;
    if (div_zero) begin
      fast_res = funct3_i[1] ? operandA_i : '1;
    end else begin
      fast_res = funct3_i[1] ? '0 : operandA_i;
    end
  end

  // Iterative step: shift-add multiply (multiplier in low half) or restoring divide
  // (dividend/quotient in low half, partial remainder in high half).
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] step_p;

  assign mul_sum   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = p_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};

  always_comb begin
    step_p = p_q;
    if (is_div_q) begin
      if (!div_diff[XLEN]) begin
        step_p = {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
      end else begin
        step_p = {div_shift[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_p = {mul_sum, p_q[XLEN-1:1]};
    end
  end

  // Sign fix-up
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;

  assign prod_fix = neg_q ? -p_q : p_q;
  assign quo      = p_q[XLEN-1:0];
  assign rem      = p_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    if (is_div_q) begin
      if (m_f3_q[1]) begin
        fix_res = neg_r_q ? -rem : rem;
      end else begin
        fix_res = neg_q ? -quo : quo;
      end
    end else begin
      fix_res = (m_f3_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      opnd_q   <= '0;
      m_f3_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      branch_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (is_m && !fast) begin
              state_q  <= CALC;
              cnt_q    <= '0;
              is_div_q <= m_div;
              m_f3_q   <= funct3_i[1:0];
              neg_q    <= sign_a ^ sign_b;
              neg_r_q  <= sign_a;
              if (m_div) begin
                p_q    <= {{XLEN{1'b0}}, mag_a};
                opnd_q <= mag_b;
              end else begin
                p_q    <= {{XLEN{1'b0}}, mag_b};
                opnd_q <= mag_a;
              end
            end else begin
              state_q  <= DONE;
              result_q <= is_m ? fast_res : base_res;
              branch_q <= is_m ? 1'b0 : base_br;
            end
          end else if (state_q == DONE && ready_i) begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          p_q <= step_p;
          if (cnt_q == LAST_IT) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          result_q <= fix_res;
          branch_q <= 1'b0;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
